// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and width helper for the arb_mux channel selector
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int DATA_W     = 32;

  // Channel-index width; never narrower than one bit so a single-channel build still has an out_sel.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant with round-robin pointer or fixed priority
// Optional packet lock when ARB_MUX_LOCK_EN is defined.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N   = 4,
  parameter int RR  = MODE_RR,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]     last_i,
`endif
  input  logic             load_en_i,
  output logic [N-1:0]     grant_o,
  output logic [SEL_W-1:0] grant_idx_o,
  output logic             xfer_o
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     req_eff;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] gidx;
  logic             found;
  logic             xfer;
  logic             adv_ok;
  int               base;
  int               idx;

`ifdef ARB_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;

  // While locked only the owning channel may compete.
  always_comb begin
    req_eff = req_i;
    if (lock_q) begin
      req_eff = '0;
      req_eff[lock_idx_q] = req_i[lock_idx_q];
    end
  end

  assign adv_ok = last_i[gidx];

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      lock_d     = !last_i[gidx];
      lock_idx_d = gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign req_eff = req_i;
  assign adv_ok  = 1'b1;
`endif

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    base  = (RR == MODE_FIXED) ? 0 : int'(ptr_q);
    for (int k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_eff[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = SEL_W'(idx);
      end
    end
  end

  assign xfer = load_en_i & (|grant);

  always_comb begin
    ptr_d = ptr_q;
    if ((RR != MODE_FIXED) && xfer && adv_ok) begin
      ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign grant_o     = grant;
  assign grant_idx_o = gidx;
  assign xfer_o      = xfer;

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-way valid/ready arbiter into a single registered output slot
// Build option ARB_MUX_LOCK_EN adds in_last and holds the grant for a whole packet.
module arb_mux
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N     = 4,
  parameter int RR    = MODE_RR,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             load_en;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // Slot accepts whenever empty or being drained this cycle; rst blocks all acceptance.
  assign load_en = (!out_valid_q | out_ready) & !rst;

  rr_arbiter #(
    .N  (N),
    .RR (RR)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (in_valid),
`ifdef ARB_MUX_LOCK_EN
    .last_i      (in_last),
`endif
    .load_en_i   (load_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .xfer_o      (xfer)
  );

  assign in_ready = grant & {N{load_en}};

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = sel_data;
        out_sel_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - scoreboard bench for arb_mux (round-robin and fixed-priority instances)
module tb_arb_mux;

  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;

  logic [N-1:0]   fp_in_valid, fp_in_ready;
  logic [N*W-1:0] fp_in_data;
  logic           fp_out_valid, fp_out_ready;
  logic [W-1:0]   fp_out_data;
  logic [1:0]     fp_out_sel;
`ifdef ARB_MUX_LOCK_EN
  logic [N-1:0]   in_last;
  logic [N-1:0]   fp_in_last;
`endif

  beat_t q_rr[$];
  beat_t q_fp[$];
  int n_checks = 0;
  int n_err    = 0;
  int rr_pops  = 0;
  int fp_pops  = 0;

  arb_mux #(.WIDTH(W), .N(N), .RR(1)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(W), .N(N), .RR(0)) u_fp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fp_in_valid),
    .in_data   (fp_in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (fp_in_last),
`endif
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_ready (fp_out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q_rr.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rr_extra_beat: got sel %0d data %0h expected no beat at %0t", out_sel, out_data, $time);
      end else begin
        beat_t b;
        b = q_rr.pop_front();
        chk("rr_data", 64'(out_data), 64'(b.d));
        chk("rr_sel", 64'(out_sel), 64'(b.s));
        rr_pops++;
      end
    end
  end

  always @(negedge clk) begin
    if (fp_out_valid === 1'b1 && fp_out_ready === 1'b1) begin
      if (q_fp.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL fp_extra_beat: got sel %0d data %0h expected no beat at %0t", fp_out_sel, fp_out_data, $time);
      end else begin
        beat_t b;
        b = q_fp.pop_front();
        chk("fp_data", 64'(fp_out_data), 64'(b.d));
        chk("fp_sel", 64'(fp_out_sel), 64'(b.s));
        fp_pops++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = '1;
    fp_in_valid = '0;
    fp_out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data[i*W +: W]    = 32'hA0 + 32'(i);
      fp_in_data[i*W +: W] = 32'hB0 + 32'(i);
    end
`ifdef ARB_MUX_LOCK_EN
    in_last = '0;
    fp_in_last = '1;
`endif

    // reset with every channel requesting
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_sel", 64'(out_sel), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // round-robin fairness, 8 back-to-back beats
    for (int i = 0; i < 8; i++) q_rr.push_back('{32'hA0 + 32'(i % 4), 2'(i % 4)});
    @(negedge clk);
    chk("first_grant", 64'(in_ready), 64'b0001);
    repeat (8) @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_beats_no_bubble", 64'(rr_pops), 64'd8);
    chk("rr_drained", 64'(out_valid), 64'd0);

    // back-pressure hold on a ch2 beat
    @(posedge clk); #1;
    in_data[2*W +: W] = 32'hDEADBEEF;
    in_valid = 4'b0100;
    q_rr.push_back('{32'hDEADBEEF, 2'd2});
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'hDEADBEEF);
      chk("hold_sel", 64'(out_sel), 64'd2);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_data[2*W +: W] = 32'hA2;
    q_rr.push_back('{32'hA0, 2'd0});
    @(negedge clk);
    chk("wrap_grant", 64'(in_ready), 64'b0001);
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);
    chk("drain_load_no_bubble", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("idle_drop_1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("idle_drop_2", 64'(out_valid), 64'd0);
    @(posedge clk); #1 in_valid = '1;
    q_rr.push_back('{32'hA1, 2'd1});
    @(negedge clk);
    chk("ptr_held_at_1", 64'(in_ready), 64'b0010);
    @(posedge clk); #1 in_valid = '0;

    // reset while a ch2 beat is pending and stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 4'b0100;
    @(posedge clk); #1;
    in_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("pend_valid", 64'(out_valid), 64'd1);
    chk("rst_forces_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 4'b1010;
    q_rr.push_back('{32'hA1, 2'd1});
    @(negedge clk);
    chk("rst_discard", 64'(out_valid), 64'd0);
    chk("rst_ptr_zero", 64'(in_ready), 64'b0010);
    @(posedge clk); #1;
    in_valid = '0;
    out_ready = 1'b1;

    // fixed priority: ch1 always beats ch3
    for (int i = 0; i < 5; i++) q_fp.push_back('{32'hB1, 2'd1});
    fp_in_valid = 4'b1010;
    repeat (5) begin
      @(negedge clk);
      chk("fp_ready", 64'(fp_in_ready), 64'b0010);
      @(posedge clk);
    end
    #1 fp_in_valid = '0;

`ifdef ARB_MUX_LOCK_EN
    // packet lock: ch0 sends 3 beats while ch1 waits
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 4'b0011;
    in_last = '0;
    for (int i = 0; i < 3; i++) q_rr.push_back('{32'hA0, 2'd0});
    q_rr.push_back('{32'hA1, 2'd1});
    @(negedge clk);
    chk("lock_first", 64'(in_ready), 64'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lock_hold", 64'(in_ready), 64'b0001);
    @(posedge clk); #1 in_last = 4'b0001;
    @(posedge clk); #1 in_last = '0;
    @(negedge clk);
    chk("lock_release", 64'(in_ready), 64'b0010);
    @(posedge clk); #1;
    q_rr.push_back('{32'hA0, 2'd0});
    @(negedge clk);
    chk("lock_ptr2_ch0", 64'(in_ready), 64'b0001);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 4'b1010;
    @(negedge clk);
    chk("lock_rst_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    q_rr.push_back('{32'hA1, 2'd1});
    @(negedge clk);
    chk("lock_cleared", 64'(in_ready), 64'b0010);
    @(posedge clk); #1 in_valid = '0;
`endif

    repeat (4) @(negedge clk);
    chk("rr_queue_empty", 64'(q_rr.size()), 64'd0);
    chk("fp_queue_empty", 64'(q_fp.size()), 64'd0);
    chk("fp_beats", 64'(fp_pops), 64'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
